bat_level_ctrl: RTL and testbench

BAT_LEVEL_CTRL -- requirements
Module: bat_level_ctrl

---
 rtl/bat_level_ctrl.sv | 168 ++++++++++++++++
 tb/tb_bat_level_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bat_level_ctrl.sv
// Battery bar level controller: frame-paced slew to a target level plus single-step requests.
// Optional charge animation is built in when the macro BAT_AUTO_ANIM_EN is defined.
module bat_level_ctrl #(
    parameter int unsigned MAX_LEVEL       = 28,
    parameter int unsigned FRAMES_PER_STEP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       tgt_valid,
    input  logic [4:0] tgt_level,
    output logic       tgt_ready,
    input  logic       inc_req,
    input  logic       dec_req,
    input  logic       anim_en,
    output logic [4:0] bat_ctl,
    output logic       busy,
    output logic       done,
    output logic       full,
    output logic       empty
);

    localparam logic [4:0] MAX_L  = 5'(MAX_LEVEL);
    localparam logic [7:0] FPS_M1 = 8'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef BAT_AUTO_ANIM_EN
        ANIM = 2'd2,
`endif
        SLEW = 2'd1
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] level_q, level_d;
    logic [4:0] target_q, target_d;
    logic [7:0] cnt_q, cnt_d;
    logic       inc_q, inc_d;
    logic       dec_q, dec_d;
    logic       done_q, done_d;
    logic       vs_meta_q, vs_sync_q, vs_prev_q;
    logic       frame_tick;
    logic       accept;
    logic       inc_eff, dec_eff;
    logic [4:0] tgt_clamped;

    // Synchronizer flops rest at 1 so reset release can never fake a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_meta_q <= 1'b1;
            vs_sync_q <= 1'b1;
            vs_prev_q <= 1'b1;
        end else begin
            vs_meta_q <= vsync;
            vs_sync_q <= vs_meta_q;
            vs_prev_q <= vs_sync_q;
        end
    end

    assign frame_tick  = vs_prev_q & ~vs_sync_q;
    assign tgt_ready   = (state_q == IDLE) & ~rst;
    assign accept      = tgt_valid & tgt_ready;
    assign tgt_clamped = (tgt_level > MAX_L) ? MAX_L : tgt_level;
    assign inc_eff     = inc_q | inc_req;
    assign dec_eff     = dec_q | dec_req;

`ifndef BAT_AUTO_ANIM_EN
    logic anim_unused;
    assign anim_unused = anim_en;
`endif

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        inc_d    = inc_q;
        dec_d    = dec_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    target_d = tgt_clamped;
                    cnt_d    = '0;
                    inc_d    = 1'b0;
                    dec_d    = 1'b0;
                    state_d  = SLEW;
                end
`ifdef BAT_AUTO_ANIM_EN
                else if (anim_en) begin
                    cnt_d   = '0;
                    inc_d   = 1'b0;
                    dec_d   = 1'b0;
                    state_d = ANIM;
                end
`endif
                else if (frame_tick) begin
                    // Conflicting requests cancel; saturated ones are simply consumed.
                    if (inc_eff && !dec_eff && level_q != MAX_L) begin
                        level_d = level_q + 5'd1;
                    end else if (dec_eff && !inc_eff && level_q != 5'd0) begin
                        level_d = level_q - 5'd1;
                    end
                    inc_d = 1'b0;
                    dec_d = 1'b0;
                end else begin
                    inc_d = inc_eff;
                    dec_d = dec_eff;
                end
            end
            SLEW: begin
                if (level_q == target_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (frame_tick) begin
                    if (cnt_q == FPS_M1) begin
                        cnt_d   = '0;
                        level_d = (target_q > level_q) ? level_q + 5'd1 : level_q - 5'd1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
`ifdef BAT_AUTO_ANIM_EN
            ANIM: begin
                if (frame_tick) begin
                    if (!anim_en) begin
                        state_d = IDLE;
                    end else if (cnt_q == FPS_M1) begin
                        cnt_d   = '0;
                        level_d = (level_q == MAX_L) ? 5'd0 : level_q + 5'd1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            level_q  <= '0;
            target_q <= '0;
            cnt_q    <= '0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
            done_q   <= done_d;
        end
    end

    assign bat_ctl = level_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign full    = (level_q == MAX_L);
    assign empty   = (level_q == 5'd0);

endmodule

// File: tb/tb_bat_level_ctrl.sv
// Self-checking bench for bat_level_ctrl (default build, BAT_AUTO_ANIM_EN undefined).
module tb_bat_level_ctrl;

    localparam int MaxLevel      = 28;
    localparam int FramesPerStep = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       vsync;
    logic       tgtValid;
    logic [4:0] tgtLevel;
    logic       tgtReady;
    logic       incReq;
    logic       decReq;
    logic       animEn;
    logic [4:0] batCtl;
    logic       busy;
    logic       done;
    logic       full;
    logic       empty;

    int compared   = 0;
    int mismatched = 0;
    int doneCount  = 0;
    int expLevel   = 0;

    bat_level_ctrl #(.MAX_LEVEL(MaxLevel), .FRAMES_PER_STEP(FramesPerStep)) dut (
        .clk(clk), .rst(rst), .vsync(vsync),
        .tgt_valid(tgtValid), .tgt_level(tgtLevel), .tgt_ready(tgtReady),
        .inc_req(incReq), .dec_req(decReq), .anim_en(animEn),
        .bat_ctl(batCtl), .busy(busy), .done(done), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) doneCount++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit valid, input int lvl, input bit inc, input bit dec);
        @(negedge clk);
        tgtValid = valid;
        tgtLevel = 5'(lvl);
        incReq   = inc;
        decReq   = dec;
        @(negedge clk);
        tgtValid = 1'b0;
        tgtLevel = 5'd0;
        incReq   = 1'b0;
        decReq   = 1'b0;
    endtask

    // One full frame: falling vsync edge, then enough time for it to be synchronized and used.
    task automatic frameTick();
        @(negedge clk);
        vsync = 1'b0;
        repeat (4) @(negedge clk);
        vsync = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Single-step request model: inc/dec cancel, saturate at 0 and MaxLevel.
    task automatic stepOp(input bit inc, input bit dec, input bit split, input string tag);
        if (split) begin
            applyStimulus(0, 0, inc, 1'b0);
            applyStimulus(0, 0, 1'b0, dec);
        end else begin
            applyStimulus(0, 0, inc, dec);
        end
        repeat (6) @(negedge clk);
        checkOutput({tag, " hold before tick"}, 32'(batCtl), 32'(expLevel));
        frameTick();
        if (inc && !dec && expLevel < MaxLevel) expLevel++;
        else if (dec && !inc && expLevel > 0) expLevel--;
        checkOutput({tag, " level"}, 32'(batCtl), 32'(expLevel));
    endtask

    // Slew model: level ramps one code every FramesPerStep frames toward the clamped target.
    task automatic runSlew(input int tgtRaw, input bit collideInc, input bit noisy, input string tag);
        int tgt, startLvl, n, doneBefore, exp;
        tgt        = (tgtRaw > MaxLevel) ? MaxLevel : tgtRaw;
        startLvl   = expLevel;
        doneBefore = doneCount;
        n          = ((tgt > startLvl) ? tgt - startLvl : startLvl - tgt) * FramesPerStep;
        applyStimulus(1, tgtRaw, collideInc, 0);
        checkOutput({tag, " busy after accept"}, 32'(busy), 32'd1);
        for (int i = 1; i <= n; i++) begin
            if (noisy && $urandom_range(0, 1) == 1)
                applyStimulus(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            frameTick();
            exp = (tgt > startLvl) ? startLvl + i / FramesPerStep : startLvl - i / FramesPerStep;
            checkOutput({tag, " level"}, 32'(batCtl), 32'(exp));
            if (i < n) checkOutput({tag, " busy"}, 32'(busy), 32'd1);
        end
        repeat (2) @(negedge clk);
        expLevel = tgt;
        checkOutput({tag, " final level"}, 32'(batCtl), 32'(tgt));
        checkOutput({tag, " done pulses"}, 32'(doneCount - doneBefore), 32'd1);
        checkOutput({tag, " busy end"}, 32'(busy), 32'd0);
        checkOutput({tag, " full"}, 32'(full), 32'(tgt == MaxLevel));
        checkOutput({tag, " empty"}, 32'(empty), 32'(tgt == 0));
    endtask

    initial begin
        int doneSnap;
        rst      = 1'b1;
        vsync    = 1'b1;
        tgtValid = 1'b0;
        tgtLevel = 5'd0;
        incReq   = 1'b0;
        decReq   = 1'b0;
        animEn   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset bat_ctl", 32'(batCtl), 32'd0);
        checkOutput("reset tgt_ready", 32'(tgtReady), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset empty", 32'(empty), 32'd1);
        checkOutput("reset full", 32'(full), 32'd0);
        rst = 1'b0;
        #1 checkOutput("ready after release", 32'(tgtReady), 32'd1);

        animEn = 1'b1;
        stepOp(0, 1, 0, "dec at zero");
        stepOp(1, 0, 0, "inc alone");
        stepOp(1, 1, 1, "inc+dec same frame");
        stepOp(0, 1, 0, "dec alone");
        animEn = 1'b0;

        runSlew(5, 0, 0, "slew up 0->5");

        doneSnap = doneCount;
        applyStimulus(1, 5, 0, 0);
        checkOutput("equal target done early", 32'(done), 32'd0);
        @(negedge clk);
        checkOutput("equal target done 2 cycles", 32'(done), 32'd1);
        @(negedge clk);
        checkOutput("equal target done count", 32'(doneCount - doneSnap), 32'd1);

        runSlew(3, 0, 0, "slew down to 3");
        runSlew(31, 0, 0, "clamp to max");
        stepOp(1, 0, 0, "inc at max");
        runSlew(0, 0, 0, "slew down to 0");

        runSlew(10, 1, 0, "collision");
        frameTick();
        checkOutput("collision inc dropped", 32'(batCtl), 32'd10);

        runSlew(7, 0, 1, "slew to 7 noisy");
        doneSnap = doneCount;
        applyStimulus(1, 20, 0, 0);
        frameTick();
        frameTick();
        checkOutput("mid slew level", 32'(batCtl), 32'd7);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset bat_ctl", 32'(batCtl), 32'd0);
        checkOutput("async reset ready", 32'(tgtReady), 32'd0);
        checkOutput("async reset busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 checkOutput("ready after mid-slew reset", 32'(tgtReady), 32'd1);
        expLevel = 0;
        for (int i = 0; i < 6; i++) frameTick();
        checkOutput("no done after reset", 32'(doneCount - doneSnap), 32'd0);
        checkOutput("level held after reset", 32'(batCtl), 32'd0);
        checkOutput("idle after reset", 32'(busy), 32'd0);

        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                stepOp(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), "random step");
            end else begin
                runSlew(int'($urandom_range(0, 31)), 0, 1, "random slew");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
